// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch PC unit.
package fetch_pkg;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        ST_START         = 2'd0,
        ST_RUN           = 2'd1,
        ST_WAIT_REDIRECT = 2'd2
    } fetch_state_e;

    // Default first fetch address after reset.
    localparam logic [31:0] FETCH_RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Instruction step between sequential fetches.
    localparam logic [31:0] FETCH_STEP = 32'd4;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: sequences instruction memory requests, follows branch cache
// predictions, and handles flush/redirect from the back end.
//
//   state            | meaning
//   -----------------+-----------------------------------------------------
//   ST_START         | first cycle after reset, no request issued
//   ST_RUN           | issuing requests at pc, advancing on each accept
//   ST_WAIT_REDIRECT | flushed, idle until a redirect supplies a new pc
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] P_RESET_VECTOR = FETCH_RESET_VECTOR_DEFAULT
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iREDIRECT_VALID,
    input  logic [31:0] iREDIRECT_ADDR,
    output logic        oMEM_REQ,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_ACK,
    output logic        oBC_SEARCH_STB,
    output logic [31:0] oBC_SEARCH_INST_ADDR,
    input  logic        iBC_SEARCH_VALID,
    input  logic        iBC_SEARCH_HIT,
    input  logic        iBC_PREDICT_BRANCH,
    input  logic [31:0] iBC_SEARCH_ADDR,
    input  logic        iFETCH_BUSY,
    output logic        oFETCH_VALID,
    output logic [31:0] oFETCH_INST_ADDR,
    output logic        oFETCH_PREDICT,
    output logic [31:0] oFETCH_PREDICT_ADDR
);

    localparam logic [31:0] RESET_PC = word_align(P_RESET_VECTOR);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic [31:0]  fetch_inst_addr_q, fetch_inst_addr_d;
    logic         fetch_predict_q, fetch_predict_d;
    logic [31:0]  fetch_predict_addr_q, fetch_predict_addr_d;

    logic         mem_req;
    logic         take;
    logic         accept;
    logic [31:0]  bc_target;
    logic [31:0]  redirect_target;

    // Low address bits are discarded by word alignment.
    logic         unused_low_addr_bits;
    assign unused_low_addr_bits = ^{iREDIRECT_ADDR[1:0], iBC_SEARCH_ADDR[1:0]};

    // Request qualification and branch prediction decode. Reset gates the
    // request so a mid-run reset cycle never presents a live request.
    always_comb begin
        mem_req         = (state_q == ST_RUN) && !iRESET_SYNC && !iFETCH_BUSY
                          && !iFLUSH && !iREDIRECT_VALID;
        take            = iBC_SEARCH_VALID && iBC_SEARCH_HIT && iBC_PREDICT_BRANCH;
        accept          = mem_req && iMEM_ACK;
        bc_target       = word_align(iBC_SEARCH_ADDR);
        redirect_target = word_align(iREDIRECT_ADDR);
    end

    assign oMEM_REQ             = mem_req;
    assign oMEM_ADDR            = pc_q;
    assign oBC_SEARCH_STB       = mem_req;
    assign oBC_SEARCH_INST_ADDR = pc_q;

    assign oFETCH_VALID         = fetch_valid_q;
    assign oFETCH_INST_ADDR     = fetch_inst_addr_q;
    assign oFETCH_PREDICT       = fetch_predict_q;
    assign oFETCH_PREDICT_ADDR  = fetch_predict_addr_q;

    // Next-state, next-pc mux and fetch slot capture. Redirect beats flush,
    // flush beats a normal accept; slot payload holds between pulses.
    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        fetch_valid_d        = 1'b0;
        fetch_inst_addr_d    = fetch_inst_addr_q;
        fetch_predict_d      = fetch_predict_q;
        fetch_predict_addr_d = fetch_predict_addr_q;

        if (iREDIRECT_VALID) begin
            state_d = ST_RUN;
            pc_d    = redirect_target;
        end else if (iFLUSH) begin
            state_d = ST_WAIT_REDIRECT;
        end else begin
            unique case (state_q)
                ST_START: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        pc_d                 = take ? bc_target : (pc_q + FETCH_STEP);
                        fetch_valid_d        = 1'b1;
                        fetch_inst_addr_d    = pc_q;
                        fetch_predict_d      = take;
                        fetch_predict_addr_d = take ? bc_target : 32'h0;
                    end
                end
                ST_WAIT_REDIRECT: begin
                    state_d = ST_WAIT_REDIRECT;
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end
    end

    // State and slot registers with synchronous reset taking priority.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q              <= ST_START;
            pc_q                 <= RESET_PC;
            fetch_valid_q        <= 1'b0;
            fetch_inst_addr_q    <= 32'h0;
            fetch_predict_q      <= 1'b0;
            fetch_predict_addr_q <= 32'h0;
        end else begin
            state_q              <= state_d;
            pc_q                 <= pc_d;
            fetch_valid_q        <= fetch_valid_d;
            fetch_inst_addr_q    <= fetch_inst_addr_d;
            fetch_predict_q      <= fetch_predict_d;
            fetch_predict_addr_q <= fetch_predict_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit with a 0x100 reset vector.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        redir_v;
    logic [31:0] redir_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        bc_stb;
    logic [31:0] bc_inst_addr;
    logic        bc_valid;
    logic        bc_hit;
    logic        bc_pred;
    logic [31:0] bc_addr;
    logic        busy;
    logic        f_valid;
    logic [31:0] f_inst_addr;
    logic        f_pred;
    logic [31:0] f_pred_addr;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_unit #(.P_RESET_VECTOR(32'h0000_0100)) dut (
        .iCLOCK               (clk),
        .iRESET_SYNC          (rst),
        .iFLUSH               (flush),
        .iREDIRECT_VALID      (redir_v),
        .iREDIRECT_ADDR       (redir_addr),
        .oMEM_REQ             (mem_req),
        .oMEM_ADDR            (mem_addr),
        .iMEM_ACK             (mem_ack),
        .oBC_SEARCH_STB       (bc_stb),
        .oBC_SEARCH_INST_ADDR (bc_inst_addr),
        .iBC_SEARCH_VALID     (bc_valid),
        .iBC_SEARCH_HIT       (bc_hit),
        .iBC_PREDICT_BRANCH   (bc_pred),
        .iBC_SEARCH_ADDR      (bc_addr),
        .iFETCH_BUSY          (busy),
        .oFETCH_VALID         (f_valid),
        .oFETCH_INST_ADDR     (f_inst_addr),
        .oFETCH_PREDICT       (f_pred),
        .oFETCH_PREDICT_ADDR  (f_pred_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs applied for one cycle, plus outputs expected during it.
    typedef struct {
        logic        rst, flush, rv;
        logic [31:0] raddr;
        logic        ack, bv, hit, pr;
        logic [31:0] baddr;
        logic        busy;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] fia;
        logic        fp;
        logic [31:0] fpa;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rst_i, input logic flush_i, input logic rv_i, input logic [31:0] raddr_i,
        input logic ack_i, input logic bv_i, input logic hit_i, input logic pr_i,
        input logic [31:0] baddr_i, input logic busy_i,
        input logic req_i, input logic [31:0] addr_i, input logic fv_i,
        input logic [31:0] fia_i, input logic fp_i, input logic [31:0] fpa_i);
        vec_t v;
        v.rst = rst_i; v.flush = flush_i; v.rv = rv_i; v.raddr = raddr_i;
        v.ack = ack_i; v.bv = bv_i; v.hit = hit_i; v.pr = pr_i;
        v.baddr = baddr_i; v.busy = busy_i;
        v.req = req_i; v.addr = addr_i; v.fv = fv_i;
        v.fia = fia_i; v.fp = fp_i; v.fpa = fpa_i;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; flush = v.flush; redir_v = v.rv; redir_addr = v.raddr;
        mem_ack = v.ack; bc_valid = v.bv; bc_hit = v.hit; bc_pred = v.pr;
        bc_addr = v.baddr; busy = v.busy;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; redir_v = 1'b0; redir_addr = 32'h0;
        mem_ack = 1'b0; bc_valid = 1'b0; bc_hit = 1'b0; bc_pred = 1'b0;
        bc_addr = 32'h0; busy = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        //             rst f rv raddr         ack bv h p baddr         busy | req addr          fv fia           fp fpa
        vecs[0]  = mk(1, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0100, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0100, 0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0100, 0, 32'h0,        0, 32'h0);
        vecs[3]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0104, 1, 32'h0000_0100, 0, 32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0108, 1, 32'h0000_0104, 0, 32'h0);
        vecs[5]  = mk(0, 0, 1, 32'h0000_0200, 1, 0, 0, 0, 32'h0,       0,   0, 32'h0000_010C, 1, 32'h0000_0108, 0, 32'h0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'h0000_0343, 0,  1, 32'h0000_0200, 0, 32'h0,        0, 32'h0);
        vecs[7]  = mk(0, 0, 1, 32'h0000_0200, 0, 0, 0, 0, 32'h0,       0,   0, 32'h0000_0340, 1, 32'h0000_0200, 1, 32'h0000_0340);
        vecs[8]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 0, 32'h0000_0340, 0,  1, 32'h0000_0200, 0, 32'h0,        0, 32'h0);
        vecs[9]  = mk(0, 0, 1, 32'h0000_0300, 0, 0, 0, 0, 32'h0,       0,   0, 32'h0000_0204, 1, 32'h0000_0200, 0, 32'h0);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 1, 1, 1, 32'h0000_0800, 0,  1, 32'h0000_0300, 0, 32'h0,        0, 32'h0);
        vecs[11] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0300, 0, 32'h0,        0, 32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0300, 0, 32'h0,        0, 32'h0);
        vecs[13] = mk(0, 0, 0, 32'h0,        1, 0, 1, 1, 32'h0000_0900, 0,  1, 32'h0000_0300, 0, 32'h0,        0, 32'h0);
        vecs[14] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        1,   0, 32'h0000_0304, 1, 32'h0000_0300, 0, 32'h0);
        vecs[15] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        1,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[16] = mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[17] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[18] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[19] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[20] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[21] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[22] = mk(0, 0, 1, 32'h0000_1003, 1, 0, 0, 0, 32'h0,       0,   0, 32'h0000_0304, 0, 32'h0,        0, 32'h0);
        vecs[23] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'h0000_1000, 0, 32'h0,        0, 32'h0);
        vecs[24] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h0,       0,   0, 32'h0000_1004, 1, 32'h0000_1000, 0, 32'h0);
        vecs[25] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0);
        vecs[26] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[27] = mk(1, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0004, 1, 32'h0000_0000, 0, 32'h0);
        vecs[28] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   0, 32'h0000_0100, 0, 32'h0,        0, 32'h0);
        vecs[29] = mk(0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0,   1, 32'h0000_0100, 0, 32'h0,        0, 32'h0);

        // Establish a known state before the table starts.
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check32($sformatf("v%0d mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].req});
            check32($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
            check32($sformatf("v%0d bc_stb", i), {31'h0, bc_stb}, {31'h0, vecs[i].req});
            check32($sformatf("v%0d bc_addr", i), bc_inst_addr, vecs[i].addr);
            check32($sformatf("v%0d fetch_valid", i), {31'h0, f_valid}, {31'h0, vecs[i].fv});
            if (vecs[i].fv) begin
                check32($sformatf("v%0d fetch_inst_addr", i), f_inst_addr, vecs[i].fia);
                check32($sformatf("v%0d fetch_predict", i), {31'h0, f_pred}, {31'h0, vecs[i].fp});
                check32($sformatf("v%0d fetch_predict_addr", i), f_pred_addr, vecs[i].fpa);
            end
            @(negedge clk);
        end

        // Flush and redirect together with ack: redirect wins, slot dropped.
        idle_inputs();
        flush = 1'b1; redir_v = 1'b1; redir_addr = 32'h0000_0502; mem_ack = 1'b1;
        #1;
        check32("flush_redir mem_req", {31'h0, mem_req}, 32'h0);
        check32("flush_redir fetch_valid", {31'h0, f_valid}, 32'h1);
        check32("flush_redir fetch_inst_addr", f_inst_addr, 32'h0000_0100);
        @(negedge clk);
        idle_inputs();
        #1;
        check32("after_flush_redir fetch_valid", {31'h0, f_valid}, 32'h0);
        check32("after_flush_redir mem_req", {31'h0, mem_req}, 32'h1);
        check32("after_flush_redir mem_addr", mem_addr, 32'h0000_0500);

        // Ack the request and wait, bounded, for its slot.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        begin
            int waited;
            waited = 0;
            #1;
            while (!f_valid && waited < 4) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check32("slot_latency", waited, 0);
            check32("slot_inst_addr", f_inst_addr, 32'h0000_0500);
        end

        // Reset asserted mid-request with ack high: no slot, restart at vector.
        @(negedge clk);
        idle_inputs();
        #1;
        check32("pre_reset mem_addr", mem_addr, 32'h0000_0504);
        check32("pre_reset mem_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        check32("in_reset mem_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check32("post_reset fetch_valid", {31'h0, f_valid}, 32'h0);
        check32("post_reset mem_addr", mem_addr, 32'h0000_0100);
        check32("post_reset start mem_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        #1;
        check32("post_reset fetch_valid2", {31'h0, f_valid}, 32'h0);
        check32("post_reset run mem_req", {31'h0, mem_req}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
